// File: rtl/rv_decode_queue.sv
// RV32I/RV64I decoder feeding a DEPTH-entry decoded-instruction FIFO; 1-cycle latency, no bypass.
// in_ready = not full (independent of out_ready); head entry held stable while out_ready is low.
module rv_decode_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic [3:0]               out_alu_op,
  output logic [2:0]               out_ls_variant,
  output logic [2:0]               out_itype,
  output logic                     out_word,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_MISC_MEM = 7'b0001111, OPC_OP_IMM = 7'b0010011,
                         OPC_AUIPC = 7'b0010111, OPC_OP_IMM_32 = 7'b0011011, OPC_STORE = 7'b0100011,
                         OPC_OP = 7'b0110011, OPC_LUI = 7'b0110111, OPC_OP_32 = 7'b0111011,
                         OPC_BRANCH = 7'b1100011, OPC_JALR = 7'b1100111, OPC_JAL = 7'b1101111,
                         OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SRA = 4'd2, ALU_SRL = 4'd3, ALU_SLL = 4'd4,
                         ALU_EQ = 4'd5, ALU_NE = 4'd6, ALU_LT = 4'd7, ALU_GE = 4'd8, ALU_LTU = 4'd9,
                         ALU_GEU = 4'd10, ALU_XOR = 4'd11, ALU_OR = 4'd12, ALU_AND = 4'd13, ALU_LUI = 4'd14;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5, T_EXC = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [2:0]      ls_variant;
    logic [2:0]      itype;
    logic            word;
    logic            illegal;
  } entry_t;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       rv64, wform, wide_sh, sh_ok, f7_ok, ill;
  logic [5:0] shamt;
  logic signed [11:0] imm_i, imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;
  entry_t dec;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rv64  = (XLEN == 64);
  assign wform = (opc == OPC_OP_IMM_32) || (opc == OPC_OP_32);
  assign imm_i = in_instr[31:20];
  assign imm_s = {in_instr[31:25], in_instr[11:7]};
  assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};

  // 6-bit shamt only for non-W shifts on RV64; upper field then shrinks by one bit
  assign wide_sh = rv64 && !wform;
  assign shamt   = wide_sh ? in_instr[25:20] : {1'b0, in_instr[24:20]};
  assign sh_ok   = wide_sh ? (in_instr[31:26] == 6'b000000 || (in_instr[31:26] == 6'b010000 && f3 == 3'd5))
                           : (f7 == 7'b0000000 || (f7 == 7'b0100000 && f3 == 3'd5));
  assign f7_ok   = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));

  always_comb begin
    dec        = '0;
    ill        = 1'b0;
    dec.pc     = in_pc;
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.alu_op = ALU_ADD;
    dec.word   = wform;
    dec.itype  = T_EXC;
    case (opc)
      OPC_LOAD: begin
        dec.itype = T_I;
        dec.imm   = XLEN'(imm_i);
        case (f3)
          3'd0: dec.ls_variant = 3'd0;
          3'd1: dec.ls_variant = 3'd1;
          3'd2: dec.ls_variant = 3'd2;
          3'd3: dec.ls_variant = 3'd6;
          3'd4: dec.ls_variant = 3'd3;
          3'd5: dec.ls_variant = 3'd4;
          3'd6: dec.ls_variant = 3'd5;
          default: ill = 1'b1;
        endcase
        if (!rv64 && (f3 == 3'd3 || f3 == 3'd6)) ill = 1'b1;
      end
      OPC_MISC_MEM: begin
        dec.itype = T_I;
        dec.imm   = XLEN'(imm_i);
        ill       = (f3 != 3'd0);
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        dec.itype = T_I;
        dec.imm   = XLEN'(imm_i);
        case (f3)
          3'd1: dec.alu_op = ALU_SLL;
          3'd2: dec.alu_op = ALU_LT;
          3'd3: dec.alu_op = ALU_LTU;
          3'd4: dec.alu_op = ALU_XOR;
          3'd5: dec.alu_op = in_instr[30] ? ALU_SRA : ALU_SRL;
          3'd6: dec.alu_op = ALU_OR;
          3'd7: dec.alu_op = ALU_AND;
          default: dec.alu_op = ALU_ADD;
        endcase
        if (f3 == 3'd1 || f3 == 3'd5) begin
          dec.imm = XLEN'(shamt);
          if (!sh_ok) ill = 1'b1;
        end
        if (wform && (!rv64 || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5))) ill = 1'b1;
      end
      OPC_OP, OPC_OP_32: begin
        dec.itype = T_R;
        case (f3)
          3'd0: dec.alu_op = f7[5] ? ALU_SUB : ALU_ADD;
          3'd1: dec.alu_op = ALU_SLL;
          3'd2: dec.alu_op = ALU_LT;
          3'd3: dec.alu_op = ALU_LTU;
          3'd4: dec.alu_op = ALU_XOR;
          3'd5: dec.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
          3'd6: dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
        if (!f7_ok) ill = 1'b1;
        if (wform && (!rv64 || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5))) ill = 1'b1;
      end
      OPC_STORE: begin
        dec.itype = T_S;
        dec.imm   = XLEN'(imm_s);
        dec.rd    = 5'd0;
        case (f3)
          3'd0: dec.ls_variant = 3'd0;
          3'd1: dec.ls_variant = 3'd1;
          3'd2: dec.ls_variant = 3'd2;
          3'd3: begin dec.ls_variant = 3'd6; ill = !rv64; end
          default: ill = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec.itype = T_B;
        dec.imm   = XLEN'(imm_b);
        dec.rd    = 5'd0;
        case (f3)
          3'd0: dec.alu_op = ALU_EQ;
          3'd1: dec.alu_op = ALU_NE;
          3'd4: dec.alu_op = ALU_LT;
          3'd5: dec.alu_op = ALU_GE;
          3'd6: dec.alu_op = ALU_LTU;
          3'd7: dec.alu_op = ALU_GEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LUI:    begin dec.itype = T_U; dec.imm = XLEN'(imm_u); dec.alu_op = ALU_LUI; end
      OPC_AUIPC:  begin dec.itype = T_U; dec.imm = XLEN'(imm_u); end
      OPC_JAL:    begin dec.itype = T_J; dec.imm = XLEN'(imm_j); end
      OPC_JALR:   begin dec.itype = T_I; dec.imm = XLEN'(imm_i); ill = (f3 != 3'd0); end
      OPC_SYSTEM: begin dec.itype = T_EXC; dec.imm = XLEN'(imm_i); end
      default:    ill = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin
      dec.imm    = '0;
      dec.alu_op = ALU_ADD;
      dec.rd     = 5'd0;
    end
    dec.illegal = ill;
  end

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           push, pop;
  entry_t         head;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign head           = mem[rd_ptr];
  assign out_pc         = head.pc;
  assign out_rd         = head.rd;
  assign out_rs1        = head.rs1;
  assign out_rs2        = head.rs2;
  assign out_imm        = head.imm;
  assign out_alu_op     = head.alu_op;
  assign out_ls_variant = head.ls_variant;
  assign out_itype      = head.itype;
  assign out_word       = head.word;
  assign out_illegal    = head.illegal;
endmodule

// File: doc/rv_decode_queue.md
# rv_decode_queue

Parametrised RV32I/RV64I instruction decoder with a decoded-instruction buffer, sitting between fetch and register read. Each accepted 32-bit instruction is fully decoded into register indices, a sign-extended immediate, an ALU op, a load/store variant and an instruction-type class. The result is stored in a DEPTH-entry FIFO and presented to register read under a valid/ready handshake. XLEN selects RV32 or RV64 legality rules, and a flush input discards all buffered entries.

## Interface
- XLEN, 64, architectural width; only 32 or 64 are legal.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  `count < DEPTH`; must not depend on `out_ready`.
- in_pc  in  XLEN  PC of the offered instruction.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  `count != 0`.
- out_ready  in  1  register read consumes the head entry.
- out_pc  out  XLEN  head entry PC.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_op  out  4  ALU op encoding: ADD=0, SUB=1, RSHIFTA=2, RSHIFTL=3, LSHIFTL=4, EQ=5, NE=6, LT=7, GE=8, LTU=9, GEU=10, XOR=11, OR=12, AND=13, ADD_MISC_OP_2_PT=14.
- out_ls_variant  out  3  load/store variant: LB=0, LH=1, LW=2, LBU=3, LHU=4, LWU=5, LD=6.
- out_itype  out  3  instruction type: R=0, I=1, S=2, B=3, U=4, J=5, EXCEPTION=6.
- out_word  out  1  32-bit W-form op (OP_IMM_32, OP_32).
- out_illegal  out  1  instruction is illegal.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Decode** is combinational on `in_instr`. The decoded fields are written into the FIFO tail on `push = in_valid & in_ready & ~flush`.
- **Pop:** `pop = out_valid & out_ready`. All outputs are driven from the head entry's registered storage.
- **Type:** out_itype is assigned by opcode as follows.
  - LOAD, MISC_MEM, OP_IMM, OP_IMM_32, JALR → I
  - STORE → S
  - BRANCH → B
  - LUI, AUIPC → U
  - JAL → J
  - OP, OP_32 → R
  - SYSTEM → EXCEPTION; SYSTEM is not marked illegal.
- **Immediates:** standard RISC-V I/S/B/U/J formats, sign-extended to XLEN. U-type is `instr[31:12]<<12`, sign-extended. Shift-immediates carry the zero-extended shamt only: `instr[25:20]` when XLEN=64 and not W-form, otherwise `instr[24:20]`.
- **rd:** forced to 0 for S and B types. All other register fields are taken as raw bits.
- **ALU op:**
  - ADD: loads, stores, AUIPC, JAL, JALR, ADD/ADDI/ADDW/ADDIW.
  - ADD_MISC_OP_2_PT: LUI.
  - SUB: SUB and SUBW.
  - Branches map BEQ/BNE/BLT/BGE/BLTU/BGEU → EQ/NE/LT/GE/LTU/GEU.
  - SLT/SLTI → LT; SLTU/SLTIU → LTU.
  - XOR/OR/AND and their I-forms → XOR/OR/AND.
  - SLL* → LSHIFTL; SRL* → RSHIFTL; SRA* → RSHIFTA.
  - Illegal, FENCE and SYSTEM → ADD.
- **ls_variant:** loads use their own variant. Stores map SB/SH/SW/SD → LB/LH/LW/LD. Everything else → 0.
- **out_illegal** is set when any of the following holds:
  - `instr[1:0] != 2'b11`;
  - the opcode is outside {LOAD, MISC_MEM, OP_IMM, AUIPC, OP_IMM_32, STORE, OP, LUI, OP_32, BRANCH, JALR, JAL, SYSTEM};
  - funct3 is undefined for the opcode;
  - for OP/OP_32, funct7 ∉ {0000000, 0100000}, or funct7 = 0100000 on anything but ADD/SUB or SRL/SRA;
  - for shift-immediates, the upper bits (`instr[31:26]` when XLEN=64 and not W-form, else `instr[31:25]`) are not 0 or 010000(0), with SLLI requiring 0;
  - XLEN=32 and the instruction is OP_IMM_32, OP_32, LD, LWU or SD.
- **Illegal entries** are still buffered in order, with imm=0, alu_op=ADD and rd=0.
- **Flush** sets the head/tail pointers and count to 0 at the edge. A push and a pop in the flush cycle are both ignored.
- **Reset:** pointers, count and all storage go to 0. All outputs are therefore 0, except in_ready=1.

## Timing
- **Latency:** an instruction accepted at edge N is visible with out_valid=1 after edge N. Minimum latency is 1 cycle; there is no bypass.
- **Simultaneous push and pop:** count is unchanged. When count=DEPTH, in_ready=0, so a push never coincides with full even if out_ready=1.
- **Pointers** wrap modulo DEPTH and count saturates at DEPTH by construction.
- **Output stability:** head-entry outputs are stable while `out_valid & ~out_ready`. When empty (out_valid=0), output values are don't-care.
- **Reset mid-operation:** asserting rst clears state immediately (asynchronously); entries in flight are lost.

## Test plan
- **Decode ADDI:** `in_instr=0xFFF00093` (addi x1,x0,-1) → the next cycle shows out_valid=1, rd=1, rs1=0, imm=all ones, alu_op=0, itype=1, illegal=0.
- **Decode BEQ / LUI / SRAIW:**
  - BEQ x1,x2,-4 (`0xFE208EE3`) → itype=3, alu_op=5, imm=-4, rd=0.
  - LUI x5,0x12345 (`0x123452B7`) → imm=0x12345000, alu_op=14.
  - SRAIW x3,x3,3 (`0x4031D19B`) → alu_op=2, imm=3, word=1.
- **XLEN=32 legality:** LD x1,0(x2) (`0x00013083`) → illegal=1; lw → illegal=0, ls_variant=2. Under XLEN=64, LD → illegal=0, ls_variant=6.
- **Back-pressure:** hold out_ready=0, push DEPTH instructions → count=DEPTH, in_ready=0; then set out_ready=1 with in_valid=1 → entries drain in PC order and none are lost or duplicated.
- **Flush with simultaneous push:** with count=3, assert flush together with in_valid=1 → count=0 and out_valid=0 the next cycle, and the pushed word never appears.
- **Illegal forms:**
  - `0x00000000` → illegal=1.
  - ADD with funct7=0000001 → illegal=1.
  - ECALL (`0x00000073`) → itype=6, illegal=0.
